// File: rtl/dmem_ctrl.sv
// Byte-addressed little-endian data memory with a valid/ready request/response
// handshake, byte/half/word access, load extension and fixed read latency.
module dmem_ctrl #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          accept;
  logic          req_err;
  logic [AW-1:0] word_idx;
  logic [3:0]    wstrb;
  logic [31:0]   wdata_rep;
  logic          wen;

  logic [31:0]   rd_word;
  logic [1:0]    lane_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic          write_q;
  logic          err_q;
  logic [31:0]   load_ext;

  // Reset outranks a request presented on the same edge.
  assign accept   = (state_q == IDLE) && i_req_valid && !i_rst;
  assign word_idx = i_req_addr[AW+1:2];
  assign wen      = accept && i_req_write && !req_err;

  always_comb begin
    req_err = 1'b0;
    case (i_req_size)
      2'b01:   req_err = i_req_addr[0];
      2'b10:   req_err = |i_req_addr[1:0];
      2'b11:   req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
    if (i_req_addr[31:AW+2] != '0) begin
      req_err = 1'b1;
    end
  end

  always_comb begin
    wstrb     = 4'b0000;
    wdata_rep = i_req_wdata;
    case (i_req_size)
      2'b00: begin
        wstrb     = 4'b0001 << i_req_addr[1:0];
        wdata_rep = {4{i_req_wdata[7:0]}};
      end
      2'b01: begin
        wstrb     = i_req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{i_req_wdata[15:0]}};
      end
      2'b10: begin
        wstrb     = 4'b1111;
        wdata_rep = i_req_wdata;
      end
      default: begin
        wstrb     = 4'b0000;
        wdata_rep = i_req_wdata;
      end
    endcase
  end

  // One byte-wide RAM per lane so each lane infers its own block RAM with a
  // registered read port; the read is taken only on the accepting edge.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem_q [DEPTH];
    logic [7:0] rd_byte_q;

    always_ff @(posedge i_clk) begin
      if (accept) begin
        if (wen && wstrb[gi]) begin
          lane_mem_q[word_idx] <= wdata_rep[8*gi +: 8];
        end
        rd_byte_q <= lane_mem_q[word_idx];
      end
    end

    assign rd_word[8*gi +: 8] = rd_byte_q;
  end

  // Request attributes are captured once; later input changes are ignored.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      lane_q  <= i_req_addr[1:0];
      size_q  <= i_req_size;
      uns_q   <= i_req_unsigned;
      write_q <= i_req_write;
      err_q   <= req_err;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (i_req_valid) begin
          cnt_d   = CW'(1);
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == CW'(LATENCY - 1)) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        if (i_rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    sel_byte = rd_word[7:0];
    sel_half = lane_q[1] ? rd_word[31:16] : rd_word[15:0];
    case (lane_q)
      2'd0:    sel_byte = rd_word[7:0];
      2'd1:    sel_byte = rd_word[15:8];
      2'd2:    sel_byte = rd_word[23:16];
      default: sel_byte = rd_word[31:24];
    endcase
    case (size_q)
      2'b00:   load_ext = {{24{sel_byte[7] & ~uns_q}}, sel_byte};
      2'b01:   load_ext = {{16{sel_half[15] & ~uns_q}}, sel_half};
      default: load_ext = rd_word;
    endcase
  end

  assign o_req_ready = (state_q == IDLE);
  assign o_rsp_valid = (state_q == RESP);
  assign o_rsp_err   = (state_q == RESP) && err_q;
  assign o_rsp_rdata = ((state_q == RESP) && !err_q && !write_q) ? load_ext : 32'h0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: three instances (LATENCY 1, 2, 15) driven
// by a directed table, hand sequences and random traffic against a byte model.
module tb_dmem_ctrl;

  localparam int DEPTH = 1024;
  localparam int NI    = 3;

  logic        clk;
  logic        rst        [NI];
  logic        req_valid  [NI];
  logic        req_ready  [NI];
  logic        req_write  [NI];
  logic [1:0]  req_size   [NI];
  logic        req_uns    [NI];
  logic [31:0] req_addr   [NI];
  logic [31:0] req_wdata  [NI];
  logic        rsp_valid  [NI];
  logic        rsp_ready  [NI];
  logic [31:0] rsp_rdata  [NI];
  logic        rsp_err    [NI];

  int checks   = 0;
  int failures = 0;

  logic [7:0] refm [NI][DEPTH*4];

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] erd;
    logic        eerr;
  } vec_t;
  vec_t tbl[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    dmem_ctrl #(
      .DEPTH  (DEPTH),
      .LATENCY((gi == 0) ? 1 : ((gi == 1) ? 2 : 15))
    ) u_dut (
      .i_clk         (clk),
      .i_rst         (rst[gi]),
      .i_req_valid   (req_valid[gi]),
      .o_req_ready   (req_ready[gi]),
      .i_req_write   (req_write[gi]),
      .i_req_size    (req_size[gi]),
      .i_req_unsigned(req_uns[gi]),
      .i_req_addr    (req_addr[gi]),
      .i_req_wdata   (req_wdata[gi]),
      .o_rsp_valid   (rsp_valid[gi]),
      .i_rsp_ready   (rsp_ready[gi]),
      .o_rsp_rdata   (rsp_rdata[gi]),
      .o_rsp_err     (rsp_err[gi])
    );
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 2 : 15);
  endfunction

  task automatic chk(input int d, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d actual=%h required=%h", name, d, act, exp);
    end
  endtask

  // Reference: memory as a flat byte array, rules applied directly.
  task automatic model(input int d, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] erd, output logic eerr);
    int n;
    logic [31:0] v;
    logic [31:0] t;
    n    = 1 << sz;
    eerr = (sz == 2'd3) || ((addr % n) != 0) || ((addr >> 2) >= DEPTH);
    erd  = 32'h0;
    if (eerr) return;
    if (wr) begin
      for (int i = 0; i < n; i++) begin
        t = wdata >> (8 * i);
        refm[d][addr + i] = t[7:0];
      end
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(refm[d][addr + i]) << (8 * i));
      if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      erd = v;
    end
  endtask

  task automatic do_req(input int d, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input int stall,
                        output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    chk(d, "req_ready_idle", 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1;
    req_write[d] = wr;
    req_size[d]  = sz;
    req_uns[d]   = uns;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
    req_write[d] = 1'($urandom);
    req_size[d]  = 2'($urandom);
    req_uns[d]   = 1'($urandom);
    req_addr[d]  = $urandom;
    req_wdata[d] = $urandom;
    lat = 1;
    while (!rsp_valid[d] && lat < 40) begin
      chk(d, "req_ready_wait", 32'(req_ready[d]), 32'd0);
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    rd = rsp_rdata[d];
    er = rsp_err[d];
    if (!rsp_valid[d]) begin
      chk(d, "rsp_timeout", 32'(rsp_valid[d]), 32'd1);
      return;
    end
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      @(negedge clk);
      chk(d, "stall_valid", 32'(rsp_valid[d]), 32'd1);
      chk(d, "stall_rdata", rsp_rdata[d], rd);
      chk(d, "stall_err", 32'(rsp_err[d]), 32'(er));
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    chk(d, "post_rsp_valid", 32'(rsp_valid[d]), 32'd0);
    chk(d, "post_req_ready", 32'(req_ready[d]), 32'd1);
    $display("txn inst=%0d wr=%0d sz=%0d uns=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
             d, wr, sz, uns, addr, wdata, rd, er, lat);
  endtask

  task automatic run_model(input int d, input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata, input int stall);
    logic [31:0] erd, rd;
    logic eerr, er;
    int lat;
    model(d, wr, sz, uns, addr, wdata, erd, eerr);
    do_req(d, wr, sz, uns, addr, wdata, stall, rd, er, lat);
    chk(d, "model_rdata", rd, erd);
    chk(d, "model_err", 32'(er), 32'(eerr));
    chk(d, "model_latency", 32'(lat), 32'(lat_of(d)));
  endtask

  task automatic add(input logic wr, input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] erd, input logic eerr);
    vec_t v;
    v.wr = wr; v.sz = sz; v.uns = uns; v.addr = addr; v.wdata = wdata; v.erd = erd; v.eerr = eerr;
    tbl.push_back(v);
  endtask

  task automatic check_idle(input int d, input string tag);
    chk(d, {tag, "_req_ready"}, 32'(req_ready[d]), 32'd1);
    chk(d, {tag, "_rsp_valid"}, 32'(rsp_valid[d]), 32'd0);
    chk(d, {tag, "_rsp_rdata"}, rsp_rdata[d], 32'h0);
    chk(d, {tag, "_rsp_err"}, 32'(rsp_err[d]), 32'd0);
  endtask

  task automatic run_instance(input int d);
    logic [31:0] rd, erd;
    logic er, eerr;
    int lat, n;
    logic [1:0] sz;
    logic [31:0] addr;

    // Directed table
    foreach (tbl[i]) begin
      model(d, tbl[i].wr, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wdata, erd, eerr);
      do_req(d, tbl[i].wr, tbl[i].sz, tbl[i].uns, tbl[i].addr, tbl[i].wdata, 0, rd, er, lat);
      chk(d, $sformatf("tbl%0d_rdata", i), rd, tbl[i].erd);
      chk(d, $sformatf("tbl%0d_err", i), 32'(er), 32'(tbl[i].eerr));
      chk(d, $sformatf("tbl%0d_latency", i), 32'(lat), 32'(lat_of(d)));
    end

    // Backpressure with a competing request held high
    @(negedge clk);
    model(d, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, erd, eerr);
    req_valid[d] = 1'b1; req_write[d] = 1'b0; req_size[d] = 2'd2; req_addr[d] = 32'h10;
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
    n = 0;
    while (!rsp_valid[d] && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk(d, "bp_first_valid", 32'(rsp_valid[d]), 32'd1);
    chk(d, "bp_first_rdata", rsp_rdata[d], erd);
    req_valid[d] = 1'b1; req_write[d] = 1'b1; req_size[d] = 2'd2; req_wdata[d] = 32'hFFFF_FFFF;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk(d, "bp_valid", 32'(rsp_valid[d]), 32'd1);
      chk(d, "bp_rdata", rsp_rdata[d], erd);
      chk(d, "bp_req_ready", 32'(req_ready[d]), 32'd0);
    end
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready[d] = 1'b0;
    check_idle(d, "bp_release");
    run_model(d, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);

    // Reset just after a store is accepted
    model(d, 1'b1, 2'd2, 1'b0, 32'h20, 32'h0102_0304, erd, eerr);
    @(negedge clk);
    req_valid[d] = 1'b1; req_write[d] = 1'b1; req_size[d] = 2'd2;
    req_addr[d] = 32'h20; req_wdata[d] = 32'h0102_0304;
    @(posedge clk);
    @(negedge clk);
    req_valid[d] = 1'b0;
    rst[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst[d] = 1'b0;
    check_idle(d, "midrst");
    run_model(d, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0);

    // Reset coinciding with a request: nothing accepted, nothing written
    @(negedge clk);
    rst[d] = 1'b1;
    req_valid[d] = 1'b1; req_write[d] = 1'b1; req_size[d] = 2'd2;
    req_addr[d] = 32'h20; req_wdata[d] = 32'hBAD0_BAD0;
    @(posedge clk);
    @(negedge clk);
    rst[d] = 1'b0;
    req_valid[d] = 1'b0;
    check_idle(d, "rstreq");
    run_model(d, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0);

    // Fill the random window so every load hits defined data
    for (int w = 0; w < 32; w++) run_model(d, 1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, 0);

    for (int r = 0; r < 120; r++) begin
      sz   = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      addr = ($urandom_range(0, 15) == 0) ? (32'(DEPTH * 4) + $urandom_range(0, 1 << 20))
                                          : 32'($urandom_range(0, 127));
      run_model(d, 1'($urandom), sz, 1'($urandom), addr, $urandom, $urandom_range(0, 2));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog inst=-1 actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int d = 0; d < NI; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_write[d] = 1'b0; req_size[d] = 2'd0;
      req_uns[d] = 1'b0; req_addr[d] = 32'h0; req_wdata[d] = 32'h0; rsp_ready[d] = 1'b0;
    end

    add(1, 2'd2, 0, 32'h00, 32'hCAFE_F00D, 32'h0, 0);
    add(1, 2'd2, 0, 32'h10, 32'hDEAD_BEEF, 32'h0, 0);
    add(0, 2'd2, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0);
    add(0, 2'd0, 0, 32'h13, 32'h0, 32'hFFFF_FFDE, 0);
    add(0, 2'd0, 1, 32'h13, 32'h0, 32'h0000_00DE, 0);
    add(0, 2'd1, 0, 32'h12, 32'h0, 32'hFFFF_DEAD, 0);
    add(0, 2'd0, 0, 32'h10, 32'h0, 32'hFFFF_FFEF, 0);
    add(1, 2'd0, 0, 32'h11, 32'hAAAA_AA55, 32'h0, 0);
    add(0, 2'd2, 0, 32'h10, 32'h0, 32'hDEAD_55EF, 0);
    add(1, 2'd1, 0, 32'h12, 32'hFFFF_1234, 32'h0, 0);
    add(0, 2'd2, 0, 32'h10, 32'h0, 32'h1234_55EF, 0);
    add(0, 2'd1, 1, 32'h12, 32'h0, 32'h0000_1234, 0);
    add(0, 2'd1, 0, 32'h10, 32'h0, 32'h0000_55EF, 0);
    add(0, 2'd0, 1, 32'h12, 32'h0, 32'h0000_0034, 0);
    add(0, 2'd2, 0, 32'h12, 32'h0, 32'h0, 1);
    add(1, 2'd1, 0, 32'h13, 32'hFFFF_FFFF, 32'h0, 1);
    add(0, 2'd3, 0, 32'h10, 32'h0, 32'h0, 1);
    add(1, 2'd3, 0, 32'h10, 32'h0, 32'h0, 1);
    add(0, 2'd2, 0, 32'h10, 32'h0, 32'h1234_55EF, 0);
    add(0, 2'd2, 0, 32'h1000, 32'h0, 32'h0, 1);
    add(1, 2'd2, 0, 32'h1000, 32'h1111_1111, 32'h0, 1);
    add(0, 2'd2, 0, 32'h00, 32'h0, 32'hCAFE_F00D, 0);
    add(0, 2'd0, 0, 32'h11, 32'h0, 32'h0000_0055, 0);
    add(1, 2'd0, 0, 32'h03, 32'h0000_0080, 32'h0, 0);
    add(0, 2'd0, 0, 32'h03, 32'h0, 32'hFFFF_FF80, 0);
    add(0, 2'd2, 0, 32'h00, 32'h0, 32'h80FE_F00D, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < NI; d++) check_idle(d, "reset");
    for (int d = 0; d < NI; d++) rst[d] = 1'b0;

    for (int d = 0; d < NI; d++) run_instance(d);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
